mc_ctrl: RTL and testbench
==========================

# mc_ctrl

Multi-cycle main controller for the RV32I-subset core. It sequences the shared datapath (PC, instruction register, register file, single ALU, unified instruction/data memory) through fetch, decode, execute, memory and writeback states, one instruction at a time. It supersedes the single-cycle control unit when the core moves to the shared-memory multi-cycle datapath. It stalls on a memory-ready handshake.

## Interface
- No parameters.
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- Op  in  7  IR[6:0], registered instruction opcode
- funct3  in  3  IR[14:12]
- funct7  in  7  IR[31:25]; only bit 5 is used
- EQ  in  1  high when ALU operands are equal
- mem_ready  in  1  memory access completes this cycle
- PCWrite  out  1  PC load enable
- AdrSrc  out  1  memory address: 0 = PC, 1 = ALUOut
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  IR and OldPC load enable
- ResultSrc  out  2  result mux: 00 ALUOut, 01 ReadData, 10 ALUResult
- ALUSrcA  out  2  A operand: 00 PC, 01 OldPC, 10 rs1
- ALUSrcB  out  2  B operand: 00 rs2, 01 ImmExt, 10 constant 4
- ALUctrl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- ImmSrc  out  2  00 I, 01 S, 10 B, 11 J
- RegWrite  out  1  register file write enable
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction
- illegal  out  1  one-cycle pulse when DECODE sees an unsupported opcode

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL.
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10.
  - IRWrite=PCWrite=mem_ready.
  - Stays in FETCH until mem_ready=1, then goes to DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, add (branch target into ALUOut). Next state by Op:
  - 0000011 (lw) or 0100011 (sw) → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BRANCH
  - 1101111 → JAL
  - any other opcode → FETCH, with illegal=1
- MEMADR: ALUSrcA=10, ALUSrcB=01, add. Next is MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: AdrSrc=1. Holds until mem_ready, then goes to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. Next FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=1 held until mem_ready. Next FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00. Next ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01. Next ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Next FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00.
  - PCWrite=EQ when funct3=000 (beq); PCWrite=~EQ when funct3=001 (bne).
  - Any other funct3 gives PCWrite=0.
  - Next FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1. Next ALUWB (writes PC+4 to rd).
- ALU decode for EXECR/EXECI:
  - funct3 000: sub only when funct7[5]=1 and Op=0110011, else add
  - 010: slt; 110: or; 111: and; other funct3: add
- ImmSrc decoded from Op in every state: lw/I-ALU 00, sw 01, branch 10, jal 11, default 00.
- Outputs not listed for a state are 0; ALUctrl defaults to add, ResultSrc and ALU selects to 00.
- instr_done=1 in these cases:
  - MEMWB, ALUWB, BRANCH
  - MEMWRITE when mem_ready=1
  - DECODE when illegal

## Timing
- All outputs are Moore, decoded from the state register, with one exception: outputs gated by mem_ready, EQ, funct3 or Op are combinational from those inputs as well.
- Async reset: the state register goes to FETCH. While rst_n=0, PCWrite, IRWrite, MemWrite and RegWrite are forced 0.
- Reset deasserted mid-instruction: the next instruction restarts at FETCH and no partial writeback is issued.
- Latency with mem_ready tied to 1:
  - lw 5 cycles; sw, R-type, I-ALU and jal 4 cycles; branch 3 cycles; illegal opcode 2 cycles.
- Each cycle of mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- Write enables are not repeated while stalled: MemWrite stays high but the memory commits only when mem_ready=1.

## Structure
- Package ctrl_pkg holds:
  - state enum
  - opcode constants (OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH, OP_JAL)
  - ALUctrl encodings
  - ResultSrc/ALUSrc/ImmSrc encodings
- Sub-module: the existing ALUdec, instantiated unchanged and driven by a 2-bit ALUOp (00 add, 01 sub, 10 funct-decoded) from the FSM.
- Expected implementation size: one sequential always block plus one combinational output decoder.

## Test plan
- Reset with mem_ready=1, then release, Op=0110011, funct3=000, funct7=0100000:
  - states FETCH→DECODE→EXECR→ALUWB
  - ALUctrl=001 in EXECR; RegWrite=1 only in cycle 4; instr_done in cycle 4
- lw with mem_ready low for 2 cycles in FETCH and 1 cycle in MEMREAD: 8 cycles total; IRWrite pulses exactly once; AdrSrc=1 for the 2 MEMREAD cycles.
- Branches in cycle 3:
  - beq with EQ=1: PCWrite=1
  - beq with EQ=0: PCWrite=0
  - bne with EQ=0: PCWrite=1
- jal: PCWrite=1 in JAL, then RegWrite=1 with ResultSrc=00 in ALUWB, ImmSrc=11 throughout.
- Op=1111111: illegal=1 and instr_done=1 in DECODE; next state FETCH; no write enable asserted.
- rst_n asserted during MEMWRITE with mem_ready=0: MemWrite drops immediately (asynchronously); after release the FSM is in FETCH.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle main controller: FSM states, opcodes
// and the datapath mux/ALU select codes it drives.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_JAL
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_READ   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    function automatic logic [1:0] imm_sel(input logic [6:0] op);
        case (op)
            OP_STORE:  imm_sel = IMM_S;
            OP_BRANCH: imm_sel = IMM_B;
            OP_JAL:    imm_sel = IMM_J;
            default:   imm_sel = IMM_I;
        endcase
    endfunction

    function automatic logic op_legal(input logic [6:0] op);
        op_legal = (op == OP_LOAD) || (op == OP_STORE) || (op == OP_R) ||
                   (op == OP_I) || (op == OP_BRANCH) || (op == OP_JAL);
    endfunction

endpackage

// File: rtl/mc_ctrl_aludec.sv
// ALU control decoder: maps the controller's ALUOp plus the instruction's
// funct fields onto the ALU operation select.
module ALUdec
    import ctrl_pkg::*;
(
    input  logic [1:0] i_alu_op,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7b5,
    input  logic       i_op_r,
    output logic [2:0] o_alu_ctrl
);

    always_comb begin
        o_alu_ctrl = ALU_ADD;
        case (i_alu_op)
            ALUOP_SUB: o_alu_ctrl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (i_funct3)
                    // addi has no subtract form, so funct7 only matters for R-type
                    3'b000:  o_alu_ctrl = (i_funct7b5 && i_op_r) ? ALU_SUB : ALU_ADD;
                    3'b010:  o_alu_ctrl = ALU_SLT;
                    3'b110:  o_alu_ctrl = ALU_OR;
                    3'b111:  o_alu_ctrl = ALU_AND;
                    default: o_alu_ctrl = ALU_ADD;
                endcase
            end
            default: o_alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle main controller: sequences fetch/decode/execute/memory/writeback
// over the shared datapath, stalling on the memory-ready handshake.
module mc_ctrl
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] Op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       EQ,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUctrl,
    output logic [1:0] ImmSrc,
    output logic       RegWrite,
    output logic       instr_done,
    output logic       illegal
);

    state_t     r_state;
    logic [1:0] w_alu_op;
    logic       w_pc_write;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_reg_write;
    logic       w_unused;

    assign w_unused = ^{funct7[6], funct7[4:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            case (r_state)
                S_FETCH:    if (mem_ready) r_state <= S_DECODE;
                S_DECODE: begin
                    case (Op)
                        OP_LOAD, OP_STORE: r_state <= S_MEMADR;
                        OP_R:              r_state <= S_EXECR;
                        OP_I:              r_state <= S_EXECI;
                        OP_BRANCH:         r_state <= S_BRANCH;
                        OP_JAL:            r_state <= S_JAL;
                        default:           r_state <= S_FETCH;
                    endcase
                end
                S_MEMADR:   r_state <= (Op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
                S_MEMREAD:  if (mem_ready) r_state <= S_MEMWB;
                S_MEMWRITE: if (mem_ready) r_state <= S_FETCH;
                S_EXECR,
                S_EXECI,
                S_JAL:      r_state <= (r_state == S_JAL || r_state == S_EXECR ||
                                        r_state == S_EXECI) ? S_ALUWB : S_FETCH;
                default:    r_state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        w_pc_write  = 1'b0;
        AdrSrc      = 1'b0;
        w_mem_write = 1'b0;
        w_ir_write  = 1'b0;
        ResultSrc   = RES_ALUOUT;
        ALUSrcA     = SRCA_PC;
        ALUSrcB     = SRCB_RS2;
        w_alu_op    = ALUOP_ADD;
        w_reg_write = 1'b0;
        instr_done  = 1'b0;
        illegal     = 1'b0;
        case (r_state)
            S_FETCH: begin
                ALUSrcB    = SRCB_FOUR;
                ResultSrc  = RES_ALURES;
                w_pc_write = mem_ready;
                w_ir_write = mem_ready;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                if (!op_legal(Op)) begin
                    illegal    = 1'b1;
                    instr_done = 1'b1;
                end
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD: AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc   = RES_READ;
                w_reg_write = 1'b1;
                instr_done  = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc      = 1'b1;
                w_mem_write = 1'b1;
                instr_done  = mem_ready;
            end
            S_EXECR: begin
                ALUSrcA  = SRCA_RS1;
                ALUSrcB  = SRCB_RS2;
                w_alu_op = ALUOP_FUNCT;
            end
            S_EXECI: begin
                ALUSrcA  = SRCA_RS1;
                ALUSrcB  = SRCB_IMM;
                w_alu_op = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                w_reg_write = 1'b1;
                instr_done  = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA    = SRCA_RS1;
                ALUSrcB    = SRCB_RS2;
                w_alu_op   = ALUOP_SUB;
                w_pc_write = (funct3 == 3'b000) ? EQ :
                             (funct3 == 3'b001) ? ~EQ : 1'b0;
                instr_done = 1'b1;
            end
            S_JAL: begin
                ALUSrcA    = SRCA_OLDPC;
                ALUSrcB    = SRCB_FOUR;
                w_pc_write = 1'b1;
            end
            default: ;
        endcase
    end

    // Reset also masks the architectural write strobes, not only the state.
    assign PCWrite  = w_pc_write  & rst_n;
    assign IRWrite  = w_ir_write  & rst_n;
    assign MemWrite = w_mem_write & rst_n;
    assign RegWrite = w_reg_write & rst_n;
    assign ImmSrc   = imm_sel(Op);

    ALUdec u_aludec (
        .i_alu_op   (w_alu_op),
        .i_funct3   (funct3),
        .i_funct7b5 (funct7[5]),
        .i_op_r     (Op == OP_R),
        .o_alu_ctrl (ALUctrl)
    );

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: table of single instructions, hand-built stall/reset
// sequences, and random instructions with random memory stalls.
module tb_mc_ctrl;

    localparam int MAXC = 32;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] Op;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       EQ;
    logic       mem_ready;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, instr_done, illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUctrl;

    mc_ctrl dut (
        .clk(clk), .rst_n(rst_n), .Op(Op), .funct3(funct3), .funct7(funct7),
        .EQ(EQ), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUctrl(ALUctrl), .ImmSrc(ImmSrc),
        .RegWrite(RegWrite), .instr_done(instr_done), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       pcw, adr, mw, irw, rw, done, ill, rdy;
        logic [1:0] res, sa, sb, imm;
        logic [2:0] alu;
    } cyc_t;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       eq;
        int         cyc;
        logic [2:0] alu3;
        logic       pcw3;
        logic [1:0] imm;
        int         rw;
        int         mw;
        int         ill;
    } vec_t;

    cyc_t tr[MAXC];
    logic pat[MAXC];
    int   plen;
    int   n;
    int   checks = 0;
    int   errors = 0;
    int   c_pcw, c_irw, c_rw, c_mwc, c_mw, c_ill, c_adr, c_immbad;
    vec_t tbl[16];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3,
                             input logic [6:0] f7, input logic eq);
        logic done;
        done = 1'b0;
        n = 0;
        for (int c = 0; c < MAXC && !done; c++) begin
            @(negedge clk);
            Op = op; funct3 = f3; funct7 = f7; EQ = eq;
            mem_ready = (c < plen) ? pat[c] : 1'b1;
            #1;
            tr[c].pcw = PCWrite;   tr[c].adr = AdrSrc;    tr[c].mw  = MemWrite;
            tr[c].irw = IRWrite;   tr[c].rw  = RegWrite;  tr[c].done = instr_done;
            tr[c].ill = illegal;   tr[c].rdy = mem_ready; tr[c].res = ResultSrc;
            tr[c].sa  = ALUSrcA;   tr[c].sb  = ALUSrcB;   tr[c].imm = ImmSrc;
            tr[c].alu = ALUctrl;
            n = c + 1;
            if (instr_done === 1'b1) done = 1'b1;
        end
        chk("instr_done_seen", {31'd0, done}, 32'd1);
        if (!done) begin
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            mem_ready = 1'b0;
        end
    endtask

    task automatic tally(input logic [1:0] exp_imm);
        c_pcw = 0; c_irw = 0; c_rw = 0; c_mwc = 0; c_mw = 0; c_ill = 0; c_adr = 0; c_immbad = 0;
        for (int c = 0; c < n; c++) begin
            c_pcw += int'(tr[c].pcw);
            c_irw += int'(tr[c].irw);
            c_rw  += int'(tr[c].rw);
            c_mw  += int'(tr[c].mw);
            c_mwc += int'(tr[c].mw & tr[c].rdy);
            c_ill += int'(tr[c].ill);
            c_adr += int'(tr[c].adr);
            if (tr[c].imm !== exp_imm) c_immbad++;
        end
    endtask

    function automatic logic [2:0] model_alu(input logic is_r, input logic [2:0] f3,
                                             input logic [6:0] f7);
        case (f3)
            3'b000:  return (is_r && f7[5]) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    task automatic push(input logic v);
        pat[plen] = v;
        plen++;
    endtask

    task automatic push_mem(input int stalls);
        for (int k = 0; k < stalls; k++) push(1'b0);
        push(1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{7'b0110011, 3'b000, 7'b0000000, 1'b0, 4, 3'b000, 1'b0, 2'b00, 1, 0, 0};
        tbl[1]  = '{7'b0110011, 3'b000, 7'b0100000, 1'b0, 4, 3'b001, 1'b0, 2'b00, 1, 0, 0};
        tbl[2]  = '{7'b0110011, 3'b010, 7'b0000000, 1'b0, 4, 3'b101, 1'b0, 2'b00, 1, 0, 0};
        tbl[3]  = '{7'b0110011, 3'b110, 7'b0000000, 1'b0, 4, 3'b011, 1'b0, 2'b00, 1, 0, 0};
        tbl[4]  = '{7'b0110011, 3'b111, 7'b0000000, 1'b0, 4, 3'b010, 1'b0, 2'b00, 1, 0, 0};
        tbl[5]  = '{7'b0010011, 3'b000, 7'b0100000, 1'b0, 4, 3'b000, 1'b0, 2'b00, 1, 0, 0};
        tbl[6]  = '{7'b0010011, 3'b100, 7'b0000000, 1'b0, 4, 3'b000, 1'b0, 2'b00, 1, 0, 0};
        tbl[7]  = '{7'b0000011, 3'b010, 7'b0000000, 1'b0, 5, 3'b000, 1'b0, 2'b00, 1, 0, 0};
        tbl[8]  = '{7'b0100011, 3'b010, 7'b0000000, 1'b0, 4, 3'b000, 1'b0, 2'b01, 0, 1, 0};
        tbl[9]  = '{7'b1100011, 3'b000, 7'b0000000, 1'b1, 3, 3'b001, 1'b1, 2'b10, 0, 0, 0};
        tbl[10] = '{7'b1100011, 3'b000, 7'b0000000, 1'b0, 3, 3'b001, 1'b0, 2'b10, 0, 0, 0};
        tbl[11] = '{7'b1100011, 3'b001, 7'b0000000, 1'b0, 3, 3'b001, 1'b1, 2'b10, 0, 0, 0};
        tbl[12] = '{7'b1100011, 3'b001, 7'b0000000, 1'b1, 3, 3'b001, 1'b0, 2'b10, 0, 0, 0};
        tbl[13] = '{7'b1100011, 3'b100, 7'b0000000, 1'b1, 3, 3'b001, 1'b0, 2'b10, 0, 0, 0};
        tbl[14] = '{7'b1101111, 3'b000, 7'b0000000, 1'b0, 4, 3'b000, 1'b1, 2'b11, 1, 0, 0};
        tbl[15] = '{7'b1111111, 3'b000, 7'b0000000, 1'b0, 2, 3'b000, 1'b0, 2'b00, 0, 0, 1};

        rst_n = 1'b0; mem_ready = 1'b1; Op = 7'b0110011; funct3 = 3'b000;
        funct7 = 7'b0; EQ = 1'b0; plen = 0;
        @(negedge clk); @(negedge clk);
        chk("rst_pcwrite", {31'd0, PCWrite}, 32'd0);
        chk("rst_irwrite", {31'd0, IRWrite}, 32'd0);
        chk("rst_memwrite", {31'd0, MemWrite}, 32'd0);
        chk("rst_regwrite", {31'd0, RegWrite}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_fetch_irwrite", {31'd0, IRWrite}, 32'd1);
        chk("post_rst_fetch_srcb", {30'd0, ALUSrcB}, 32'd2);
        chk("post_rst_fetch_adrsrc", {31'd0, AdrSrc}, 32'd0);
        mem_ready = 1'b0;

        for (int i = 0; i < 16; i++) begin
            plen = 0;
            run_instr(tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].eq);
            tally(tbl[i].imm);
            chk($sformatf("tbl%0d_cycles", i), n, tbl[i].cyc);
            chk($sformatf("tbl%0d_irwrite_cnt", i), c_irw, 1);
            chk($sformatf("tbl%0d_regwrite_cnt", i), c_rw, tbl[i].rw);
            chk($sformatf("tbl%0d_regwrite_last", i), {31'd0, tr[n-1].rw}, tbl[i].rw);
            chk($sformatf("tbl%0d_memwrite_cnt", i), c_mwc, tbl[i].mw);
            chk($sformatf("tbl%0d_illegal_cnt", i), c_ill, tbl[i].ill);
            chk($sformatf("tbl%0d_pcwrite_cnt", i), c_pcw, 1 + int'(tbl[i].pcw3));
            chk($sformatf("tbl%0d_immsrc_bad", i), c_immbad, 0);
            if (tbl[i].cyc >= 3 && n >= 3) begin
                chk($sformatf("tbl%0d_aluctrl_c3", i), {29'd0, tr[2].alu}, {29'd0, tbl[i].alu3});
                chk($sformatf("tbl%0d_pcwrite_c3", i), {31'd0, tr[2].pcw}, {31'd0, tbl[i].pcw3});
            end
        end

        // lw: two FETCH stalls, one MEMREAD stall
        plen = 0;
        push(1'b0); push(1'b0); push(1'b1); push(1'b1);
        push(1'b1); push(1'b0); push(1'b1); push(1'b1);
        run_instr(7'b0000011, 3'b010, 7'b0, 1'b0);
        tally(2'b00);
        chk("lw_stall_cycles", n, 8);
        chk("lw_stall_irwrite_cnt", c_irw, 1);
        chk("lw_stall_adrsrc_cnt", c_adr, 2);
        chk("lw_stall_wb_result", {30'd0, tr[n-1].res}, 32'd1);

        // reset asserted while a store is stalled in MEMWRITE
        plen = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            Op = 7'b0100011; funct3 = 3'b010; mem_ready = 1'b1;
        end
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        chk("sw_memwrite_before_rst", {31'd0, MemWrite}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("sw_memwrite_async_drop", {31'd0, MemWrite}, 32'd0);
        chk("sw_rst_adrsrc", {31'd0, AdrSrc}, 32'd0);
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        chk("rst_hold_pcwrite", {31'd0, PCWrite}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("after_rst_fetch_irwrite", {31'd0, IRWrite}, 32'd1);
        mem_ready = 1'b0;
        run_instr(7'b0110011, 3'b000, 7'b0, 1'b0);
        tally(2'b00);
        chk("after_rst_r_cycles", n, 4);
        chk("after_rst_r_regwrite_cnt", c_rw, 1);
        chk("after_rst_r_memwrite_cnt", c_mw, 0);

        // random instructions with random stalls
        for (int i = 0; i < 40; i++) begin
            int         cls, k0, k1, exp_rw, exp_pc;
            logic [6:0] op, f7;
            logic [2:0] f3;
            logic       eq, taken;
            cls = $urandom_range(0, 6);
            k0  = $urandom_range(0, 2);
            k1  = $urandom_range(0, 2);
            f3  = 3'($urandom_range(0, 7));
            f7  = ($urandom_range(0, 1) == 1) ? 7'b0100000 : 7'($urandom);
            eq  = 1'($urandom);
            plen = 0;
            push_mem(k0);
            case (cls)
                0: begin op = 7'b0000011; push(1'($urandom)); push(1'($urandom));
                         push_mem(k1); push(1'($urandom)); end
                1: begin op = 7'b0100011; push(1'($urandom)); push(1'($urandom));
                         push_mem(k1); end
                2: begin op = 7'b0110011; repeat (3) push(1'($urandom)); end
                3: begin op = 7'b0010011; repeat (3) push(1'($urandom)); end
                4: begin op = 7'b1100011; repeat (2) push(1'($urandom)); end
                5: begin op = 7'b1101111; repeat (3) push(1'($urandom)); end
                default: begin
                    op = 7'($urandom);
                    while (op == 7'b0000011 || op == 7'b0100011 || op == 7'b0110011 ||
                           op == 7'b0010011 || op == 7'b1100011 || op == 7'b1101111)
                        op = 7'($urandom);
                    push(1'($urandom));
                end
            endcase
            taken  = (cls == 4) && ((f3 == 3'b000 && eq) || (f3 == 3'b001 && !eq));
            exp_rw = (cls == 0 || cls == 2 || cls == 3 || cls == 5) ? 1 : 0;
            exp_pc = 1 + ((cls == 5 || taken) ? 1 : 0);
            run_instr(op, f3, f7, eq);
            tally((cls == 1) ? 2'b01 : (cls == 4) ? 2'b10 : (cls == 5) ? 2'b11 : 2'b00);
            chk($sformatf("rnd%0d_cycles", i), n, plen);
            chk($sformatf("rnd%0d_irwrite_cnt", i), c_irw, 1);
            chk($sformatf("rnd%0d_regwrite_cnt", i), c_rw, exp_rw);
            chk($sformatf("rnd%0d_regwrite_last", i), {31'd0, tr[n-1].rw}, exp_rw);
            chk($sformatf("rnd%0d_memwrite_commit", i), c_mwc, (cls == 1) ? 1 : 0);
            chk($sformatf("rnd%0d_memwrite_high", i), c_mw, (cls == 1) ? k1 + 1 : 0);
            chk($sformatf("rnd%0d_pcwrite_cnt", i), c_pcw, exp_pc);
            chk($sformatf("rnd%0d_illegal_cnt", i), c_ill, (cls == 6) ? 1 : 0);
            chk($sformatf("rnd%0d_immsrc_bad", i), c_immbad, 0);
            if (exp_rw == 1)
                chk($sformatf("rnd%0d_wb_result", i), {30'd0, tr[n-1].res},
                    (cls == 0) ? 32'd1 : 32'd0);
            if ((cls == 2 || cls == 3) && n >= 2)
                chk($sformatf("rnd%0d_exec_aluctrl", i), {29'd0, tr[n-2].alu},
                    {29'd0, model_alu(cls == 2, f3, f7)});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
